// File: rtl/vga_timing_rgb.sv
// VGA raster timing generator with registered R/G/B split of a 24-bit {R,G,B} pixel word.
// Optional `TEST_PATTERN_EN adds pattern_sel to replace pixel_in with 8 vertical colour bars.
module vga_timing_rgb #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter logic        SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [23:0] pixel_in,
`ifdef TEST_PATTERN_EN
  input  logic        pattern_sel,
`endif
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        active,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        frame_start
);

  localparam logic [9:0] H_VIS      = 10'(H_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] H_LAST     = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_VIS      = 10'(V_ACTIVE);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [9:0] V_LAST     = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);

  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        hs_on;
  logic        vs_on;
  logic [23:0] src;

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        if (v_cnt == V_LAST) v_cnt <= '0;
        else                 v_cnt <= v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 10'd1;
      end
    end
  end

  assign x      = h_cnt;
  assign y      = v_cnt;
  assign active = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_on  = (h_cnt >= H_SYNC_BEG) && (h_cnt <= H_SYNC_END);
  assign vs_on  = (v_cnt >= V_SYNC_BEG) && (v_cnt <= V_SYNC_END);

`ifdef TEST_PATTERN_EN
  localparam int unsigned BAR_W = H_ACTIVE / 8;

  logic [2:0]  bar;
  logic [23:0] bar_rgb;

  // Bar index bits map directly onto inverted channels: R=~bar[1], G=~bar[2], B=~bar[0].
  always_comb begin
    bar = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (h_cnt >= 10'(i * BAR_W)) bar = 3'(i);
    end
    bar_rgb = {{8{~bar[1]}}, {8{~bar[2]}}, {8{~bar[0]}}};
  end

  always_comb begin
    src = pixel_in;
    if (pattern_sel) src = bar_rgb;
  end
`else
  always_comb begin
    src = pixel_in;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r           <= '0;
      g           <= '0;
      b           <= '0;
      blank_n     <= 1'b0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      frame_start <= 1'b0;
    end else begin
      // Evaluated every clk so the pulse lasts one clk even when pix_en is a slower tick.
      frame_start <= pix_en && (h_cnt == '0) && (v_cnt == '0);
      if (pix_en) begin
        if (active) {r, g, b} <= src;
        else        {r, g, b} <= '0;
        blank_n <= active;
        hsync   <= hs_on ? SYNC_POL : ~SYNC_POL;
        vsync   <= vs_on ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_rgb.sv
// Directed bench for vga_timing_rgb on a reduced raster (25 x 13) so whole frames fit a short run.
// Build with +define+TEST_PATTERN_EN to also cover the colour-bar generator.
module tb_vga_timing_rgb;
  localparam int HA = 16, HF = 2, HS = 4, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;  // 25
  localparam int VT = VA + VF + VS + VB;  // 13
  localparam int FT = HT * VT;            // 325

  logic        clk = 1'b0;
  logic        rst;
  logic        pix_en;
  logic [23:0] pixel_in;
  logic [23:0] pix_const;
  logic        dyn;
  logic [9:0]  x, y;
  logic        active;
  logic [7:0]  r, g, b;
  logic        hsync, vsync, blank_n, frame_start;
`ifdef TEST_PATTERN_EN
  logic        pattern_sel = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  assign pixel_in = dyn ? {x[7:0], y[7:0], 8'h3C} : pix_const;

  vga_timing_rgb #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .pixel_in(pixel_in),
`ifdef TEST_PATTERN_EN
    .pattern_sel(pattern_sel),
`endif
    .x(x), .y(y), .active(active), .r(r), .g(g), .b(b),
    .hsync(hsync), .vsync(vsync), .blank_n(blank_n), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; pix_en = 1'b1; dyn = 1'b0; pix_const = 24'hA1B2C3;
    repeat (3) tick();
    n_cmp++; if (x !== 10'd0) begin n_err++; $display("FAIL rst_x: got %0d expected 0", x); end
    n_cmp++; if (y !== 10'd0) begin n_err++; $display("FAIL rst_y: got %0d expected 0", y); end
    n_cmp++; if ({r, g, b} !== 24'h0) begin n_err++; $display("FAIL rst_rgb: got %h expected 000000", {r, g, b}); end
    n_cmp++; if (blank_n !== 1'b0) begin n_err++; $display("FAIL rst_blank_n: got %b expected 0", blank_n); end
    n_cmp++; if ({hsync, vsync} !== 2'b11) begin n_err++; $display("FAIL rst_sync: got %b expected 11", {hsync, vsync}); end
    n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL rst_frame_start: got %b expected 0", frame_start); end
  endtask

  task automatic test_pixel_path();
    rst = 1'b0;
    tick();
    n_cmp++; if (x !== 10'd1) begin n_err++; $display("FAIL pix_first_x: got %0d expected 1", x); end
    n_cmp++; if ({r, g, b} !== 24'hA1B2C3) begin n_err++; $display("FAIL pix_first_rgb: got %h expected a1b2c3", {r, g, b}); end
    n_cmp++; if (blank_n !== 1'b1) begin n_err++; $display("FAIL pix_first_blank_n: got %b expected 1", blank_n); end
    n_cmp++; if (frame_start !== 1'b1) begin n_err++; $display("FAIL pix_first_fs: got %b expected 1", frame_start); end
    tick();
    n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL pix_fs_width: got %b expected 0", frame_start); end
    for (int i = 0; i < HT && x != 10'(HA); i++) tick();
    n_cmp++; if (x !== 10'(HA)) begin n_err++; $display("FAIL pix_reach_edge: got x=%0d expected %0d", x, HA); end
    n_cmp++; if ({r, g, b, blank_n} !== {24'hA1B2C3, 1'b1}) begin n_err++; $display("FAIL pix_last_vis: got %h/%b expected a1b2c3/1", {r, g, b}, blank_n); end
    tick();
    n_cmp++; if ({r, g, b, blank_n} !== 25'h0) begin n_err++; $display("FAIL pix_first_blank: got %h/%b expected 000000/0", {r, g, b}, blank_n); end
    n_cmp++; if (active !== 1'b0) begin n_err++; $display("FAIL pix_active_off: got %b expected 0", active); end
    dyn = 1'b1;
    for (int i = 0; i < 2 * HT && !(x == 10'd3 && y == 10'd1); i++) tick();
    n_cmp++; if ({x, y} !== {10'd3, 10'd1}) begin n_err++; $display("FAIL pix_dyn_reach: got %0d,%0d expected 3,1", x, y); end
    n_cmp++; if ({r, g, b} !== 24'h02013C) begin n_err++; $display("FAIL pix_dyn_align: got %h expected 02013c", {r, g, b}); end
    dyn = 1'b0;
  endtask

  task automatic test_frame_timing();
    int nfall = 0, fall1 = -1, fall2 = -1, fall1_x = -1;
    int vfx = -1, vfy = -1, hlow = 0, vlow = 0, fscnt = 0, fs1 = -1, fs2 = -1, fsx = -1, fsy = -1;
    logic phs, pvs;
    for (int t = 0; t < 2 * FT + 50; t++) begin
      phs = hsync; pvs = vsync;
      tick();
      if (phs && !hsync) begin
        if (nfall == 0) begin fall1 = t; fall1_x = int'(x); end
        else if (nfall == 1) fall2 = t;
        nfall++;
      end
      if (pvs && !vsync && vfx < 0) begin vfx = int'(x); vfy = int'(y); end
      if (t < HT && !hsync) hlow++;
      if (t < FT && !vsync) vlow++;
      if (t < FT && frame_start) fscnt++;
      if (frame_start) begin
        if (fs1 < 0) begin fs1 = t; fsx = int'(x); fsy = int'(y); end
        else if (fs2 < 0) fs2 = t;
      end
    end
    n_cmp++; if (fall1_x != HA + HF + 1) begin n_err++; $display("FAIL hs_start_pos: got x=%0d expected %0d", fall1_x, HA + HF + 1); end
    n_cmp++; if (hlow != HS) begin n_err++; $display("FAIL hs_width: got %0d expected %0d", hlow, HS); end
    n_cmp++; if (fall2 - fall1 != HT) begin n_err++; $display("FAIL line_period: got %0d expected %0d", fall2 - fall1, HT); end
    n_cmp++; if (vlow != VS * HT) begin n_err++; $display("FAIL vs_width: got %0d expected %0d", vlow, VS * HT); end
    n_cmp++; if (vfx != 1 || vfy != VA + VF) begin n_err++; $display("FAIL vs_start_pos: got %0d,%0d expected 1,%0d", vfx, vfy, VA + VF); end
    n_cmp++; if (fscnt != 1) begin n_err++; $display("FAIL fs_per_frame: got %0d expected 1", fscnt); end
    n_cmp++; if (fs2 - fs1 != FT) begin n_err++; $display("FAIL fs_period: got %0d expected %0d", fs2 - fs1, FT); end
    n_cmp++; if (fsx != 1 || fsy != 0) begin n_err++; $display("FAIL fs_pos: got %0d,%0d expected 1,0", fsx, fsy); end
  endtask

  task automatic test_enable_gating();
    logic [47:0] snap;
    int nfall = 0, fall1 = -1, fall2 = -1;
    logic phs;
    rst = 1'b1; pix_en = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8 * HT; i++) begin
      pix_en = (i % 2 == 0);
      snap = {x, y, r, g, b, hsync, vsync, blank_n, active};
      phs = hsync;
      tick();
      if (phs && !hsync) begin
        if (nfall == 0) fall1 = i; else if (nfall == 1) fall2 = i;
        nfall++;
      end
      if (i == 0) begin
        n_cmp++; if ({x, frame_start} !== {10'd1, 1'b1}) begin n_err++; $display("FAIL gate_first: got x=%0d fs=%b expected x=1 fs=1", x, frame_start); end
      end
      if (!pix_en) begin
        n_cmp++; if ({x, y, r, g, b, hsync, vsync, blank_n, active} !== snap) begin n_err++; $display("FAIL gate_hold: got %h expected %h at i=%0d", {x, y, r, g, b, hsync, vsync, blank_n, active}, snap, i); end
        n_cmp++; if (frame_start !== 1'b0) begin n_err++; $display("FAIL gate_fs: got %b expected 0 at i=%0d", frame_start, i); end
      end
    end
    n_cmp++; if (fall2 - fall1 != 2 * HT) begin n_err++; $display("FAIL gate_line_period: got %0d expected %0d", fall2 - fall1, 2 * HT); end
    pix_en = 1'b1;
  endtask

  task automatic test_midframe_reset();
    int cnt = 0;
    int hs_x = -1;
    for (int i = 0; i < FT + HT && !(x == 10'd20 && y == 10'd9); i++) tick();
    n_cmp++; if ({x, y} !== {10'd20, 10'd9}) begin n_err++; $display("FAIL mid_reach: got %0d,%0d expected 20,9", x, y); end
    n_cmp++; if ({hsync, vsync} !== 2'b00) begin n_err++; $display("FAIL mid_sync_pre: got %b expected 00", {hsync, vsync}); end
    rst = 1'b1;
    tick();
    n_cmp++; if ({x, y} !== 20'd0) begin n_err++; $display("FAIL mid_rst_xy: got %0d,%0d expected 0,0", x, y); end
    n_cmp++; if ({hsync, vsync, blank_n, frame_start} !== 4'b1100) begin n_err++; $display("FAIL mid_rst_ctl: got %b expected 1100", {hsync, vsync, blank_n, frame_start}); end
    n_cmp++; if ({r, g, b} !== 24'h0) begin n_err++; $display("FAIL mid_rst_rgb: got %h expected 000000", {r, g, b}); end
    rst = 1'b0;
    tick();
    n_cmp++; if ({x, frame_start, hsync, vsync} !== {10'd1, 3'b111}) begin n_err++; $display("FAIL mid_restart: got x=%0d fs/hs/vs=%b expected x=1 111", x, {frame_start, hsync, vsync}); end
    for (cnt = 1; cnt <= FT + 10; cnt++) begin
      tick();
      if (!hsync && hs_x < 0) hs_x = int'(x);
      if (frame_start) break;
    end
    n_cmp++; if (hs_x != HA + HF + 1) begin n_err++; $display("FAIL mid_hs_first: got x=%0d expected %0d", hs_x, HA + HF + 1); end
    n_cmp++; if (cnt != FT) begin n_err++; $display("FAIL mid_next_fs: got %0d expected %0d", cnt, FT); end
  endtask

`ifdef TEST_PATTERN_EN
  task automatic test_pattern();
    logic [23:0] bars [8];
    bars[0] = 24'hFFFFFF; bars[1] = 24'hFFFF00; bars[2] = 24'h00FFFF; bars[3] = 24'h00FF00;
    bars[4] = 24'hFF00FF; bars[5] = 24'hFF0000; bars[6] = 24'h0000FF; bars[7] = 24'h000000;
    pix_const = 24'h123456;
    rst = 1'b1; pix_en = 1'b1; pattern_sel = 1'b1;
    tick();
    rst = 1'b0;
    for (int h = 0; h < HA; h++) begin
      tick();
      n_cmp++; if ({r, g, b} !== bars[h / 2]) begin n_err++; $display("FAIL pat_bar_h%0d: got %h expected %h", h, {r, g, b}, bars[h / 2]); end
    end
    tick();
    n_cmp++; if ({r, g, b, blank_n} !== 25'h0) begin n_err++; $display("FAIL pat_blank: got %h/%b expected 000000/0", {r, g, b}, blank_n); end
    pattern_sel = 1'b0;
    for (int i = 0; i < 2 * HT && !(x == 10'd1 && y == 10'd1); i++) tick();
    n_cmp++; if ({r, g, b} !== 24'h123456) begin n_err++; $display("FAIL pat_off: got %h expected 123456", {r, g, b}); end
  endtask
`endif

  initial begin
    test_reset();
    test_pixel_path();
    test_frame_timing();
    test_enable_gating();
    test_midframe_reset();
`ifdef TEST_PATTERN_EN
    test_pattern();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/vga_timing_rgb.md
Name: vga_timing_rgb

Overview:
- Downstream consumer of the 24-bit concatenated pixel word {R,G,B}.
- Generates VGA raster timing (640x480@60 default), issues the x/y coordinate of the pixel to fetch, and splits the incoming 24-bit word into registered R/G/B outputs.
- Produces the sync and blank signals for the DAC/connector.
- Sits between the pixel source/concatenation stage and the board VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync active level (0 = active-low)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_en  in  1  pixel-clock enable (e.g. 25 MHz tick from 50 MHz clk)
- pixel_in  in  24  pixel word {R[23:16],G[15:8],B[7:0]}, valid combinationally for current x/y
- x  out  10  current horizontal count
- y  out  10  current vertical count
- active  out  1  high when x<H_ACTIVE and y<V_ACTIVE (combinational from counters)
- r, g, b  out  8 each  registered colour outputs
- hsync, vsync  out  1  registered sync outputs
- blank_n  out  1  registered, high during visible pixels
- frame_start  out  1  one-clk pulse per frame

Behaviour:
- H_TOTAL = sum of H params (800). V_TOTAL = sum of V params (525).
- Counters:
  - h_cnt advances only on clk edges with pix_en=1.
  - h_cnt wraps H_TOTAL-1 -> 0; on that wrap v_cnt increments.
  - v_cnt wraps V_TOTAL-1 -> 0.
  - x = h_cnt, y = v_cnt (stage 0, unregistered).
- Output stage (updates only when pix_en=1), one pix_en period of latency behind x/y:
  - r/g/b <= active ? pixel_in fields : 0.
  - blank_n <= active.
  - hsync <= SYNC_POL when h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] ([656,751]); otherwise ~SYNC_POL.
  - vsync <= SYNC_POL when v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] ([490,491]); otherwise ~SYNC_POL.
  - All outputs are therefore mutually aligned.
- frame_start: high for exactly one clk, on the clk edge with pix_en=1 where h_cnt=0 and v_cnt=0 are sampled into the output stage.
- pix_en=0: counters and all registered outputs hold.
- Reset:
  - Takes effect at the next clk edge regardless of pix_en; rst dominates pix_en.
  - h_cnt=v_cnt=0; r=g=b=0; blank_n=0; hsync=vsync=~SYNC_POL; frame_start=0.
- Reset mid-frame: restart from (0,0) with no partial sync pulse beyond the reset clk.
- Simultaneous h and v wrap at (799,524): both counters go to 0 on the same edge.

Optional Feature:
TEST_PATTERN_EN
- Defined:
  - Adds input pattern_sel (1 bit).
  - When pattern_sel=1, the output stage ignores pixel_in and drives 8 vertical colour bars, each H_ACTIVE/8 = 80 px wide, in the order white, yellow, cyan, green, magenta, red, blue, black (channels 8'hFF/8'h00).
  - Timing is unchanged.
- Undefined: no pattern_sel port; pixel_in is always used.

Test Plan:
- Reset: rst=1 for 3 clk with pix_en=1 -> x=y=0, r=g=b=0, blank_n=0, hsync=vsync=1, frame_start=0.
- Pixel path: pix_en=1 every clk, pixel_in=24'hA1B2C3 -> after the first pix_en r=8'hA1, g=8'hB2, b=8'hC3, blank_n=1; output for h=640 gives rgb=0, blank_n=0.
- Line/frame timing:
  - hsync low for exactly 96 pix_en periods, starting at output of h=656; line period 800.
  - vsync low for 1600 pix_en periods (lines 490-491).
  - frame_start pulses exactly once per 420000 pix_en periods.
- Enable gating: pix_en high every 2nd clk -> counters advance once per 2 clk; outputs stable on clk edges with pix_en=0; line period 1600 clk.
- Mid-frame reset: rst=1 for 1 clk at h=300, v=200 -> next clk x=y=0 and outputs at reset values; next frame_start occurs 420000 pix_en periods later.
- TEST_PATTERN_EN defined, pattern_sel=1 -> output for x=0 is FFFFFF, x=80 is FFFF00, x=560 is 000000; pattern_sel=0 passes pixel_in.
